// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, control bundle layout
// and the bubble constant. Consumed by id_ex_stage and its hazard detector.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;

  // Control bundle bit positions
  localparam int REGWRITE  = 0;
  localparam int MEMTOREG  = 1;
  localparam int MEMREAD   = 2;
  localparam int MEMWRITE  = 3;
  localparam int ALUSRC    = 4;
  localparam int BRANCH    = 5;
  localparam int ALUOP_LSB = 6;
  localparam int ALUOP_MSB = 7;

  // Control bundle of an inserted bubble: writes nothing anywhere
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef logic [4:0] reg_idx_t;

  // True when a WB write targets a real register that ID is reading
  function automatic logic wb_fwd_hit(input logic     wb_we,
                                      input reg_idx_t wb_rd,
                                      input reg_idx_t rd_idx);
    return wb_we && (wb_rd != '0) && (wb_rd == rd_idx);
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX. x0 never creates a hazard.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic     ex_valid_i,
  input  logic     ex_memread_i,
  input  reg_idx_t ex_rdaddr_i,
  input  logic     id_valid_i,
  input  reg_idx_t id_rs1addr_i,
  input  reg_idx_t id_rs2addr_i,
  input  logic     id_rs1_used_i,
  input  logic     id_rs2_used_i,
  output logic     load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used_i && (id_rs1addr_i == ex_rdaddr_i);
  assign rs2_hit = id_rs2_used_i && (id_rs2addr_i == ex_rdaddr_i);

  assign load_use_o = ex_valid_i && ex_memread_i && id_valid_i &&
                      (ex_rdaddr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, optional
// WB->ID bypass (enabled by defining ID_WB_BYPASS_EN) and a saturating
// stall-cycle counter. Latency is one cycle; there is no backpressure.
module id_ex_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [4:0]        id_rs1addr_i,
  input  logic [4:0]        id_rs2addr_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [4:0]        id_rdaddr_i,
  input  logic [XLEN-1:0]   id_rs1data_i,
  input  logic [XLEN-1:0]   id_rs2data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic              wb_regwrite_i,
  input  logic [4:0]        wb_rdaddr_i,
  input  logic [XLEN-1:0]   wb_rddata_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [4:0]        ex_rs1addr_o,
  output logic [4:0]        ex_rs2addr_o,
  output logic [4:0]        ex_rdaddr_o,
  output logic [XLEN-1:0]   ex_rs1data_o,
  output logic [XLEN-1:0]   ex_rs2data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  import riscv_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1addr;
    logic [4:0]        rs2addr;
    logic [4:0]        rdaddr;
    logic [XLEN-1:0]   rs1data;
    logic [XLEN-1:0]   rs2data;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_reg_t          ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic [XLEN-1:0]  rs1_fwd;
  logic [XLEN-1:0]  rs2_fwd;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_q.valid),
    .ex_memread_i  (ex_q.ctrl[MEMREAD]),
    .ex_rdaddr_i   (ex_q.rdaddr),
    .id_valid_i    (id_valid_i),
    .id_rs1addr_i  (id_rs1addr_i),
    .id_rs2addr_i  (id_rs2addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .load_use_o    (load_use)
  );

  // A flush squashes the ID instruction, so holding the front end is pointless
  assign stall_o = load_use && !flush_i;

`ifdef ID_WB_BYPASS_EN
  // The register file commits at the same edge, so its read data is stale
  // whenever WB is writing the register ID reads this cycle.
  assign rs1_fwd = wb_fwd_hit(wb_regwrite_i, wb_rdaddr_i, id_rs1addr_i) ? wb_rddata_i : id_rs1data_i;
  assign rs2_fwd = wb_fwd_hit(wb_regwrite_i, wb_rdaddr_i, id_rs2addr_i) ? wb_rddata_i : id_rs2data_i;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite_i, wb_rdaddr_i, wb_rddata_i};
  assign rs1_fwd   = id_rs1data_i;
  assign rs2_fwd   = id_rs2data_i;
`endif

  // Next EX contents: bubble on flush or load-use, otherwise capture ID
  always_comb begin
    ex_d = '0;
    if (!flush_i && !load_use) begin
      ex_d.valid   = id_valid_i;
      ex_d.pc      = id_pc_i;
      ex_d.rs1addr = id_rs1addr_i;
      ex_d.rs2addr = id_rs2addr_i;
      ex_d.rdaddr  = id_rdaddr_i;
      ex_d.rs1data = rs1_fwd;
      ex_d.rs2data = rs2_fwd;
      ex_d.imm     = id_imm_i;
      ex_d.ctrl    = id_valid_i ? id_ctrl_i : CTRL_NOP;
    end
  end

  // Stall counter advances on every stalled edge and sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
  end

  // Pipeline register and counter state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_pc_o      = ex_q.pc;
  assign ex_rs1addr_o = ex_q.rs1addr;
  assign ex_rs2addr_o = ex_q.rs2addr;
  assign ex_rdaddr_o  = ex_q.rdaddr;
  assign ex_rs1data_o = ex_q.rs1data;
  assign ex_rs2data_o = ex_q.rs2data;
  assign ex_imm_o     = ex_q.imm;
  assign ex_ctrl_o    = ex_q.ctrl;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage (CNT_W=4 so counter saturation is reachable).
// Driver applies one ID slot per cycle at negedge and pushes the expected
// EX contents / stall / counter; a monitor pops and compares after each edge.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] C_LW  = 8'b0001_0111;  // regwrite, memtoreg, memread, alusrc
  localparam logic [7:0] C_ADD = 8'b1000_0001;  // regwrite, aluop=2

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT signals
  logic              id_valid, id_rs1_used, id_rs2_used, flush, wb_we, stall;
  logic [XLEN-1:0]   id_pc, id_rs1data, id_rs2data, id_imm, wb_data;
  logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl, ex_ctrl;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1data, ex_rs2data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0]  stall_cnt;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1addr_i(id_rs1), .id_rs2addr_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rdaddr_i(id_rd), .id_rs1data_i(id_rs1data), .id_rs2data_i(id_rs2data),
    .id_imm_i(id_imm), .id_ctrl_i(id_ctrl), .flush_i(flush),
    .wb_regwrite_i(wb_we), .wb_rdaddr_i(wb_rd), .wb_rddata_i(wb_data),
    .stall_o(stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_rs1addr_o(ex_rs1), .ex_rs2addr_o(ex_rs2), .ex_rdaddr_o(ex_rd),
    .ex_rs1data_o(ex_rs1data), .ex_rs2data_o(ex_rs2data),
    .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl), .stall_cnt_o(stall_cnt)
  );

  // Reference model state and scoreboard
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
  } ex_t;

  typedef struct packed {
    logic       chk_stall;
    logic       stall;
    ex_t        ex;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  ex_t  m_ex = '0;
  int   m_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  // Next ID slot, staged by the scenario code and applied by step()
  logic        s_rst = 1'b0, s_v = 1'b0, s_u1 = 1'b0, s_u2 = 1'b0, s_flush = 1'b0, s_wbw = 1'b0;
  logic [4:0]  s_rs1 = '0, s_rs2 = '0, s_rd = '0, s_wba = '0;
  logic [31:0] s_pc = '0, s_d1 = '0, s_d2 = '0, s_imm = '0, s_wbd = '0;
  logic [7:0]  s_ctrl = '0;

  task automatic instr(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic [7:0] ctrl);
    s_v = v; s_rs1 = rs1; s_u1 = u1; s_rs2 = rs2; s_u2 = u2; s_rd = rd; s_ctrl = ctrl;
    s_pc = $urandom; s_d1 = $urandom; s_d2 = $urandom; s_imm = $urandom;
    s_flush = 1'b0; s_wbw = 1'b0; s_wba = '0; s_wbd = '0;
  endtask

  // Apply one cycle of stimulus and predict the outcome of the next edge
  task automatic step();
    exp_t e;
    ex_t  nx;
    logic hz;
    @(negedge clk);
    rst_n = s_rst; id_valid = s_v; id_pc = s_pc; id_rs1 = s_rs1; id_rs2 = s_rs2;
    id_rs1_used = s_u1; id_rs2_used = s_u2; id_rd = s_rd; id_rs1data = s_d1;
    id_rs2data = s_d2; id_imm = s_imm; id_ctrl = s_ctrl; flush = s_flush;
    wb_we = s_wbw; wb_rd = s_wba; wb_data = s_wbd;

    // An ID reader of a non-zero register being loaded by EX must wait
    hz = m_ex.valid && m_ex.ctrl[2] && s_v && (m_ex.rd != 0) &&
         ((s_u1 && s_rs1 == m_ex.rd) || (s_u2 && s_rs2 == m_ex.rd));
    e.chk_stall = s_rst;
    e.stall     = hz && !s_flush;

    nx = '0;
    if (s_rst && !s_flush && !hz) begin
      nx.valid = s_v; nx.pc = s_pc; nx.rs1 = s_rs1; nx.rs2 = s_rs2; nx.rd = s_rd;
      nx.d1 = s_d1; nx.d2 = s_d2; nx.imm = s_imm;
      nx.ctrl = s_v ? s_ctrl : 8'h00;
`ifdef ID_WB_BYPASS_EN
      if (s_wbw && s_wba != 0 && s_wba == s_rs1) nx.d1 = s_wbd;
      if (s_wbw && s_wba != 0 && s_wba == s_rs2) nx.d2 = s_wbd;
`endif
    end
    if (!s_rst) m_cnt = 0;
    else if (e.stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    m_ex  = nx;
    e.ex  = nx;
    e.cnt = 4'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample stall late in the cycle, registered outputs after the edge
  initial begin : monitor
    exp_t e;
    logic st;
    forever begin
      @(negedge clk);
      #4 st = stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_stall) chk("stall", 32'(st), 32'(e.stall));
        chk("ex_valid",   32'(ex_valid), 32'(e.ex.valid));
        chk("ex_pc",      ex_pc,         e.ex.pc);
        chk("ex_rs1addr", 32'(ex_rs1),   32'(e.ex.rs1));
        chk("ex_rs2addr", 32'(ex_rs2),   32'(e.ex.rs2));
        chk("ex_rdaddr",  32'(ex_rd),    32'(e.ex.rd));
        chk("ex_rs1data", ex_rs1data,    e.ex.d1);
        chk("ex_rs2data", ex_rs2data,    e.ex.d2);
        chk("ex_imm",     ex_imm,        e.ex.imm);
        chk("ex_ctrl",    32'(ex_ctrl),  32'(e.ex.ctrl));
        chk("stall_cnt",  32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  // Scenarios
  initial begin : driver
    int waited;
    rst_n = 1'b0; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd = '0; id_rs1data = '0;
    id_rs2data = '0; id_imm = '0; id_ctrl = '0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;

    // reset held two cycles with a live ID instruction
    s_rst = 1'b0;
    instr(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, C_LW); step(); step();
    s_rst = 1'b1;

    // load-use on rs1: one stall cycle, bubble, then the add captures
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, C_LW);  step();
    instr(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, C_ADD); step(); step();

    // load to x0 never stalls
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0, C_LW);  step();
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, C_ADD); step();

    // unused rs2 matching the load destination does not stall
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, C_LW);  step();
    instr(1'b1, 5'd8, 1'b1, 5'd5, 1'b0, 5'd6, C_ADD); step();

    // flush during a load-use condition wins: no stall, bubble, count unchanged
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, C_LW);  step();
    instr(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, C_ADD); s_flush = 1'b1; step();
    instr(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, C_ADD); step();

    // invalid ID: fields captured, control zeroed
    instr(1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, C_LW); step();

    // WB write to a register being read in ID
    instr(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd4, C_ADD);
    s_d1 = 32'h11; s_wbw = 1'b1; s_wba = 5'd9; s_wbd = 32'hDEAD; step();
    instr(1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 5'd4, C_ADD);
    s_d2 = 32'h22; s_wbw = 1'b1; s_wba = 5'd9; s_wbd = 32'hBEEF; step();
    instr(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd4, C_ADD);
    s_d1 = 32'h11; s_wbw = 1'b1; s_wba = 5'd0; s_wbd = 32'hDEAD; step();

    // drive the stall counter past all-ones
    repeat (18) begin
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, C_LW);  step();
      instr(1'b1, 5'd3, 1'b0, 5'd5, 1'b1, 5'd6, C_ADD); step();
      step();
    end

    // randomized traffic on a small register window to provoke hazards
    repeat (300) begin
      instr(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom));
      s_flush = ($urandom_range(0, 9) == 0);
      s_wbw   = 1'($urandom);
      s_wba   = 5'($urandom_range(0, 7));
      s_wbd   = $urandom;
      step();
    end

    // drain the scoreboard within a bounded number of cycles
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
